// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: drives one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digits,
// with a double-buffered digit image and an all-anodes-off guard gap at every digit switch.
// Build option: define LZ_SUPPRESS_EN to enable leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_code, sh_code;
  logic [NUM_DIGITS-1:0]   act_blank, sh_blank;
  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic                    frame_end;
  logic                    commit;

  // Per-digit "anode must stay dark" flags, evaluated from the active image only.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    logic [3:0] c;
`ifdef LZ_SUPPRESS_EN
    logic lead;
    lead = 1'b1;
`endif
    c    = 4'd0;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      c       = act_code[4*k +: 4];
      supp[k] = act_blank[k] || (c > 4'd9);
`ifdef LZ_SUPPRESS_EN
      if (k != 0 && lead && c == 4'd0) supp[k] = 1'b1;
      lead = lead && (c == 4'd0 || act_blank[k]);
`endif
    end
  end

  assign frame_end = (state_q == SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
  assign commit    = pending && (frame_end || state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        state_d = GUARD;
        cnt_d   = '0;
        idx_d   = '0;
      end
      GUARD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GRD_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable overrides everything: go dark and restart the scan from digit 0.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_comb begin
    sel_d = '1;
    if (enable && state_q == SHOW && !supp[idx_q]) sel_d[idx_q] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the digit buffers are
  // reset too, so the display never shows power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_code    <= '0;
      act_blank   <= '0;
      sh_code     <= '0;
      sh_blank    <= '0;
      pending     <= 1'b0;
      num         <= 4'd0;
      digit_sel_n <= '1;
      frame_tick  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (commit) begin
        act_code  <= sh_code;
        act_blank <= sh_blank;
      end
      // A load coincident with a commit still lands in the shadow, so pending stays set.
      if (load) begin
        sh_code  <= digits_in;
        sh_blank <= blank_in;
        pending  <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      num         <= act_code[4*idx_q +: 4];
      digit_sel_n <= sel_d;
      frame_tick  <= (state_d == SHOW) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, GUARD_CYCLES=2).
// Reference model tracks the frame position as plain arithmetic plus buffer arrays.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int G  = 2;
  localparam int FR = N * P;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  blank_in;
  logic [3:0]    num;
  logic [N-1:0]  digit_sel_n;
  logic          frame_tick;
  logic          pending;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD_CYCLES(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .digits_in   (digits_in),
    .blank_in    (blank_in),
    .num         (num),
    .digit_sel_n (digit_sel_n),
    .frame_tick  (frame_tick),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Reference model: scanning flag, position within the frame, and both images.
  logic [3:0] m_act [N];
  logic [3:0] m_sh  [N];
  logic [N-1:0] m_actb, m_shb;
  bit m_pend, m_run;
  int m_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_act[k] = 4'd0;
      m_sh[k]  = 4'd0;
    end
    m_actb = '0;
    m_shb  = '0;
    m_pend = 1'b0;
    m_run  = 1'b0;
    m_f    = 0;
  endtask

  function automatic bit m_dark(input int d);
    bit dark;
    dark = m_actb[d] || (m_act[d] > 4'd9);
`ifdef LZ_SUPPRESS_EN
    if (d > 0 && m_act[d] == 4'd0) begin
      bit lead;
      lead = 1'b1;
      for (int j = d + 1; j < N; j++)
        if (!(m_act[j] == 4'd0 || m_actb[j])) lead = 1'b0;
      if (lead) dark = 1'b1;
    end
`endif
    return dark;
  endfunction

  // One clock: predict outputs from the model, clock the DUT, compare, advance the model.
  task automatic step();
    int d, pos, nf;
    bit nrun, commit, e_ft, e_pend, ld;
    logic [3:0] e_sel, e_num;
    logic [4*N-1:0] din;
    logic [N-1:0] bin;
    ld  = load;
    din = digits_in;
    bin = blank_in;
    d   = m_f / P;
    pos = m_f % P;
    e_sel = 4'hF;
    if (enable && m_run && pos >= G && !m_dark(d)) e_sel[d] = 1'b0;
    e_num  = m_run ? m_act[d] : m_act[0];
    commit = m_pend && (!m_run || m_f == FR - 1);
    if (!enable)     begin nrun = 1'b0; nf = 0; end
    else if (!m_run) begin nrun = 1'b1; nf = 0; end
    else             begin nrun = 1'b1; nf = (m_f + 1) % FR; end
    e_ft   = nrun && nf == FR - 1;
    e_pend = ld || (m_pend && !commit);
    @(posedge clk);
    #1;
    check("digit_sel_n", digit_sel_n, e_sel);
    check("num", num, e_num);
    check("frame_tick", frame_tick, e_ft);
    check("pending", pending, e_pend);
    if (commit) begin
      m_act  = m_sh;
      m_actb = m_shb;
    end
    if (ld) begin
      for (int k = 0; k < N; k++) m_sh[k] = din[4*k +: 4];
      m_shb = bin;
    end
    m_pend = e_pend;
    m_run  = nrun;
    m_f    = nf;
  endtask

  task automatic do_load(input logic [4*N-1:0] dig, input logic [N-1:0] blk);
    load      = 1'b1;
    digits_in = dig;
    blank_in  = blk;
    step();
    load = 1'b0;
  endtask

  // Step until frame_tick is visible, bounded to two frames.
  task automatic wait_ft();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 2 * FR);
    if (!frame_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ft: frame_tick never seen within %0d cycles", 2 * FR);
    end
  endtask

  // Called in the frame_tick cycle: skip the commit edge, then collect which anodes
  // light during the following frame, plus num mid-way through digit 0's SHOW.
  task automatic frame_lit(output logic [N-1:0] lit, output logic [3:0] num_d0);
    lit    = '0;
    num_d0 = 4'd0;
    step();
    for (int i = 0; i < FR; i++) begin
      step();
      lit |= ~digit_sel_n;
      if (i == 4) num_d0 = num;
    end
  endtask

  typedef struct {
    int         edge_n;
    logic [3:0] sel;
    logic       ft;
  } vec_t;

  vec_t tbl [12];
  logic [N-1:0] lit;
  logic [3:0]   nd0;

  initial begin
    tbl[0]  = '{1,  4'hF, 1'b0};
    tbl[1]  = '{3,  4'hF, 1'b0};
    tbl[2]  = '{4,  4'hE, 1'b0};
    tbl[3]  = '{9,  4'hE, 1'b0};
    tbl[4]  = '{10, 4'hF, 1'b0};
    tbl[5]  = '{12, 4'hD, 1'b0};
    tbl[6]  = '{20, 4'hB, 1'b0};
    tbl[7]  = '{28, 4'h7, 1'b0};
    tbl[8]  = '{32, 4'h7, 1'b1};
    tbl[9]  = '{33, 4'h7, 1'b0};
    tbl[10] = '{34, 4'hF, 1'b0};
    tbl[11] = '{36, 4'hE, 1'b0};

    reset     = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    blank_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset num", num, 4'd0);
    check("reset digit_sel_n", digit_sel_n, 4'hF);
    check("reset frame_tick", frame_tick, 1'b0);
    check("reset pending", pending, 1'b0);
    reset  = 1'b0;
    enable = 1'b1;

    // Basic scan pattern from reset with an all-zero image.
    begin
      int vi;
      vi = 0;
      for (int e = 1; e <= 36; e++) begin
        step();
        if (vi < 12 && tbl[vi].edge_n == e) begin
          check($sformatf("tbl sel edge %0d", e), digit_sel_n, tbl[vi].sel);
          check($sformatf("tbl ft edge %0d", e), frame_tick, tbl[vi].ft);
          check($sformatf("tbl num edge %0d", e), num, 4'd0);
          vi++;
        end
      end
    end

    // Mid-frame load waits for the frame boundary.
    do_load(16'h1234, 4'b0000);
    check("load sets pending", pending, 1'b1);
    wait_ft();
    check("pending held to frame_tick", pending, 1'b1);
    step();
    check("pending cleared by commit", pending, 1'b0);
    check("last slot keeps old data", num, 4'd0);
    step();
    check("new frame digit0", num, 4'd4);
    repeat (8) step();
    check("new frame digit1", num, 4'd3);

    // Code > 9 and blank mask suppression.
    do_load(16'h0A09, 4'b0100);
    wait_ft();
    frame_lit(lit, nd0);
`ifdef LZ_SUPPRESS_EN
    check("lit 0A09/0100", lit, 4'b0001);
`else
    check("lit 0A09/0100", lit, 4'b1011);
`endif
    check("digit0 shows 9", nd0, 4'd9);

    // Load coincident with a commit: old shadow goes active, new one waits a frame.
    repeat (3) step();
    do_load(16'h5555, 4'b0000);
    wait_ft();
    do_load(16'h6666, 4'b0000);
    check("coincident load keeps pending", pending, 1'b1);
    step();
    check("prior shadow active", num, 4'd5);
    wait_ft();
    step();
    step();
    check("new data one frame later", num, 4'd6);
    check("pending clear after 2nd commit", pending, 1'b0);

    // Enable dropped during digit 2's SHOW, then re-enabled.
    wait_ft();
    repeat (21) step();
    check("digit2 lit before drop", digit_sel_n, 4'b1011);
    enable = 1'b0;
    step();
    check("dark after enable drop", digit_sel_n, 4'hF);
    repeat (3) step();
    enable = 1'b1;
    repeat (3) step();
    check("restart guard", digit_sel_n, 4'hF);
    step();
    check("restart digit0", digit_sel_n, 4'hE);

    // Asynchronous reset mid-SHOW with a pending load.
    repeat (3) step();
    do_load(16'h7777, 4'b0000);
    check("pending before reset", pending, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async num", num, 4'd0);
    check("async digit_sel_n", digit_sel_n, 4'hF);
    check("async frame_tick", frame_tick, 1'b0);
    check("async pending", pending, 1'b0);
    model_reset();
    #2 reset = 1'b0;

    // Leading-zero cases.
    do_load(16'h0050, 4'b0000);
    wait_ft();
    frame_lit(lit, nd0);
`ifdef LZ_SUPPRESS_EN
    check("lit 0050", lit, 4'b0011);
`else
    check("lit 0050", lit, 4'b1111);
`endif
    do_load(16'h0000, 4'b0000);
    wait_ft();
    frame_lit(lit, nd0);
`ifdef LZ_SUPPRESS_EN
    check("lit 0000", lit, 4'b0001);
`else
    check("lit 0000", lit, 4'b1111);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [4*N-1:0] dg;
      for (int k = 0; k < N; k++)
        dg[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      enable    = ($urandom_range(0, 299) != 0);
      load      = ($urandom_range(0, 39) == 0);
      digits_in = dg;
      blank_in  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
